// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state encoding and 7-segment patterns for the elevator controller
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  // seg[6] = a ... seg[0] = g, active-high
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };
  localparam logic [6:0] SEG_DASH = 7'b0000001;

endpackage

// File: rtl/elevator_seg7.sv
// rtl/elevator_seg7.sv - registered floor index to 7-segment decoder; floors >= 10 show a dash
module elevator_seg7 #(
  parameter int FLOOR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOOR_W-1:0] floor_i,
  output logic [6:0]         seg_o
);
  import elevator_pkg::*;

  logic [6:0] seg_d, seg_q;

  always_comb begin
    seg_d = SEG_DASH;
    for (int d = 0; d < 10; d++) begin
      if (int'(floor_i) == d) seg_d = SEG_DIGIT[d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_q <= SEG_DIGIT[0];
    else       seg_q <= seg_d;
  end

  assign seg_o = seg_q;

endmodule

// File: rtl/elevator_ctrl_n.sv
// rtl/elevator_ctrl_n.sv - N-floor SCAN elevator controller with timed travel and door intervals
// Optional SEG_DISPLAY_EN adds a registered 7-segment floor display output.
module elevator_ctrl_n #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_FLOORS-1:0]         call_req,
  output logic [$clog2(NUM_FLOORS)-1:0] floor_status,
  output logic                          door,
  output logic                          moving_up,
  output logic                          moving_down,
  output logic [NUM_FLOORS-1:0]         pending
`ifdef SEG_DISPLAY_EN
  ,
  output logic [6:0]                    seg
`endif
);
  import elevator_pkg::*;

  localparam int FLOOR_W = $clog2(NUM_FLOORS);
  localparam int TW      = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW      = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] r, input logic [FLOOR_W-1:0] f);
    any_above = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (r[i] && (i > int'(f))) any_above = 1'b1;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] r, input logic [FLOOR_W-1:0] f);
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (r[i] && (i < int'(f))) any_below = 1'b1;
  endfunction

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d, arr_floor;
  logic [TW-1:0]         travel_q, travel_d;
  logic [DW-1:0]         door_cnt_q, door_cnt_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, req_eff;
  logic                  door_q, up_q, down_q;
  logic                  above, below, above_arr, below_arr, going_up;

  always_comb begin
    req_eff    = pending_q | call_req;
    going_up   = (state_q == MOVE_UP);
    arr_floor  = going_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    above      = any_above(req_eff, floor_q);
    below      = any_below(req_eff, floor_q);
    above_arr  = any_above(req_eff, arr_floor);
    below_arr  = any_below(req_eff, arr_floor);
    state_d    = state_q;
    floor_d    = floor_q;
    travel_d   = travel_q;
    door_cnt_d = door_cnt_q;
    dir_up_d   = dir_up_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (req_eff[floor_q]) begin
            state_d    = DOOR_OPEN;
            door_cnt_d = '0;
          end else if (above) begin
            state_d  = MOVE_UP;
            travel_d = '0;
          end else if (below) begin
            state_d  = MOVE_DOWN;
            travel_d = '0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (travel_q == TRAVEL_LAST) begin
            floor_d  = arr_floor;
            travel_d = '0;
            dir_up_d = going_up;
            if (req_eff[arr_floor]) begin
              state_d    = DOOR_OPEN;
              door_cnt_d = '0;
            end else if (going_up ? above_arr : below_arr) begin
              state_d = state_q;
            end else if (going_up ? below_arr : above_arr) begin
              state_d = going_up ? MOVE_DOWN : MOVE_UP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            travel_d = travel_q + TW'(1);
          end
        end
        DOOR_OPEN: begin
          // A hall call at the open floor extends the door instead of queuing
          if (call_req[floor_q]) begin
            door_cnt_d = '0;
          end else if (door_cnt_q == DOOR_LAST) begin
            travel_d = '0;
            if (dir_up_q ? above : below) begin
              state_d = dir_up_q ? MOVE_UP : MOVE_DOWN;
            end else if (dir_up_q ? below : above) begin
              state_d  = dir_up_q ? MOVE_DOWN : MOVE_UP;
              dir_up_d = ~dir_up_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            door_cnt_d = door_cnt_q + DW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    pending_d = req_eff;
    if (state_d == DOOR_OPEN) pending_d[floor_d] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      floor_q    <= '0;
      travel_q   <= '0;
      door_cnt_q <= '0;
      dir_up_q   <= 1'b1;
      pending_q  <= '0;
      door_q     <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      travel_q   <= travel_d;
      door_cnt_q <= door_cnt_d;
      dir_up_q   <= dir_up_d;
      pending_q  <= pending_d;
      door_q     <= (state_d == DOOR_OPEN);
      up_q       <= (state_d == MOVE_UP);
      down_q     <= (state_d == MOVE_DOWN);
    end
  end

  assign floor_status = floor_q;
  assign door         = door_q;
  assign moving_up    = up_q;
  assign moving_down  = down_q;
  assign pending      = pending_q;

`ifdef SEG_DISPLAY_EN
  elevator_seg7 #(.FLOOR_W(FLOOR_W)) u_seg7 (
    .clk     (clk),
    .reset   (reset),
    .floor_i (floor_q),
    .seg_o   (seg)
  );
`endif

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb/tb_elevator_ctrl_n.sv - directed self-checking bench for elevator_ctrl_n (4 floors, travel 4, door 3)
module tb_elevator_ctrl_n;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] call_req;
  logic [1:0] floor_status;
  logic       door;
  logic       moving_up;
  logic       moving_down;
  logic [3:0] pending;
`ifdef SEG_DISPLAY_EN
  logic [6:0] seg;
`endif

  int passed = 0;
  int total  = 0;

  elevator_ctrl_n #(
    .NUM_FLOORS    (4),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .call_req     (call_req),
    .floor_status (floor_status),
    .door         (door),
    .moving_up    (moving_up),
    .moving_down  (moving_down),
    .pending      (pending)
`ifdef SEG_DISPLAY_EN
    ,
    .seg          (seg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b1;
    call_req = 4'b0000;
    tick(2);
    reset    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    call_req = 4'b0000;
    tick(2);
    chk("rst_floor", floor_status, 2'd0);
    chk("rst_door", door, 1'b0);
    chk("rst_up", moving_up, 1'b0);
    chk("rst_down", moving_down, 1'b0);
    chk("rst_pending", pending, 4'b0000);
`ifdef SEG_DISPLAY_EN
    chk("rst_seg", seg, 7'b1111110);
`endif

    // call at the current floor: door opens, no movement
    reset = 1'b0;
    call_req = 4'b0001;
    tick(1);
    call_req = 4'b0000;
    chk("s2_door_open", door, 1'b1);
    chk("s2_pending", pending, 4'b0000);
    chk("s2_up", moving_up, 1'b0);
    chk("s2_down", moving_down, 1'b0);
    tick(2);
    chk("s2_door_last", door, 1'b1);
    tick(1);
    chk("s2_door_closed", door, 1'b0);
    chk("s2_up_after", moving_up, 1'b0);

    // single call to top floor
    do_reset();
    call_req = 4'b1000;
    tick(1);
    call_req = 4'b0000;
    chk("s1_up", moving_up, 1'b1);
    chk("s1_floor0", floor_status, 2'd0);
    chk("s1_pending", pending, 4'b1000);
    tick(3);
    chk("s1_floor0_hold", floor_status, 2'd0);
    tick(1);
    chk("s1_floor1", floor_status, 2'd1);
    tick(4);
    chk("s1_floor2", floor_status, 2'd2);
    tick(4);
    chk("s1_floor3", floor_status, 2'd3);
    chk("s1_door", door, 1'b1);
    chk("s1_up_off", moving_up, 1'b0);
    chk("s1_pending_clr", pending, 4'b0000);
    tick(2);
    chk("s1_door_last", door, 1'b1);
    tick(1);
    chk("s1_door_closed", door, 1'b0);
    chk("s1_idle_up", moving_up, 1'b0);
    chk("s1_idle_down", moving_down, 1'b0);

    // call behind the car mid-travel is served after the top floor
    do_reset();
    call_req = 4'b1000;
    tick(1);
    call_req = 4'b0000;
    tick(4);
    chk("s3_floor1", floor_status, 2'd1);
    tick(1);
    call_req = 4'b0001;
    tick(1);
    call_req = 4'b0000;
    chk("s3_pending", pending, 4'b1001);
    tick(6);
    chk("s3_floor3", floor_status, 2'd3);
    chk("s3_door3", door, 1'b1);
    chk("s3_pending3", pending, 4'b0001);
    tick(3);
    chk("s3_down", moving_down, 1'b1);
    chk("s3_door3_closed", door, 1'b0);
    tick(4);
    chk("s3_floor2", floor_status, 2'd2);
    tick(8);
    chk("s3_floor0", floor_status, 2'd0);
    chk("s3_door0", door, 1'b1);
    chk("s3_pending0", pending, 4'b0000);
    chk("s3_down_off", moving_down, 1'b0);

    // door extend at floor 2
    do_reset();
    call_req = 4'b0100;
    tick(1);
    call_req = 4'b0000;
    tick(8);
    chk("s4_floor2", floor_status, 2'd2);
    chk("s4_door", door, 1'b1);
    tick(1);
    call_req = 4'b0100;
    tick(1);
    call_req = 4'b0000;
    chk("s4_door_ext", door, 1'b1);
    chk("s4_pending", pending, 4'b0000);
    tick(2);
    chk("s4_door_ext_last", door, 1'b1);
    tick(1);
    chk("s4_door_closed", door, 1'b0);
    chk("s4_idle_up", moving_up, 1'b0);

    // freeze mid-travel; calls still latched
    do_reset();
    call_req = 4'b1000;
    tick(1);
    call_req = 4'b0000;
    tick(1);
    enable   = 1'b0;
    call_req = 4'b0010;
    tick(1);
    call_req = 4'b0000;
    chk("s5_pending_frozen", pending, 4'b1010);
    tick(9);
    chk("s5_floor_frozen", floor_status, 2'd0);
    chk("s5_up_frozen", moving_up, 1'b1);
    enable = 1'b1;
    tick(2);
    chk("s5_floor_before", floor_status, 2'd0);
    tick(1);
    chk("s5_floor1", floor_status, 2'd1);
    chk("s5_door1", door, 1'b1);
    chk("s5_pending1", pending, 4'b1000);

    // asynchronous reset between edges mid-move
    do_reset();
    call_req = 4'b1000;
    tick(1);
    call_req = 4'b0000;
    tick(9);
    chk("s6_floor2", floor_status, 2'd2);
    chk("s6_up", moving_up, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("s6_floor_rst", floor_status, 2'd0);
    chk("s6_up_rst", moving_up, 1'b0);
    chk("s6_down_rst", moving_down, 1'b0);
    chk("s6_door_rst", door, 1'b0);
    chk("s6_pending_rst", pending, 4'b0000);
`ifdef SEG_DISPLAY_EN
    chk("s6_seg_rst", seg, 7'b1111110);
`endif
    tick(1);
    reset = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
Parametrised N-floor elevator controller; next generation of the 4-floor calling-status elevator.
- Latches floor calls into a pending-request register.
- Schedules car travel SCAN-style: keeps the current direction while requests remain ahead.
- Models per-floor travel time and a timed door-open interval.
- Drives floor index, door and direction outputs.
- Top-level block of the elevator design; the optional 7-seg display decode sits beside it.

Parameters:
NUM_FLOORS, 4, number of floors (>=2); floor index width FLOOR_W = $clog2(NUM_FLOORS), localparam
TRAVEL_CYCLES, 8, enabled clock cycles to move one floor (>=1)
DOOR_CYCLES, 16, enabled clock cycles the door stays open (>=1)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
enable  in  1  high = timers and FSM advance; low = freeze (requests still latched)
call_req  in  NUM_FLOORS  bit i high = call for floor i; level or pulse, sampled each posedge
floor_status  out  FLOOR_W  current car floor, registered
door  out  1  high while in DOOR_OPEN
moving_up  out  1  high in MOVE_UP
moving_down  out  1  high in MOVE_DOWN
pending  out  NUM_FLOORS  latched outstanding requests

Behaviour:
- One clock, clk; reset is asynchronous and active-high.
- Reset values (immediate, mid-operation included):
  - state=IDLE, floor_status=0, pending=0, door=0, moving_up=0, moving_down=0
  - travel/door counters=0, dir_up=1
- Request capture:
  - each posedge: pending <= pending | call_req, except the bit of floor_status while in DOOR_OPEN, or while entering it
  - set-to-visible latency: 1 cycle
- Terms:
  - req_eff = pending | call_req
  - above = any req_eff bit > floor_status
  - below = any req_eff bit < floor_status
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- All transitions are gated by enable=1; when enable=0, state, counters and floor are held.
- IDLE, priority order:
  - req_eff[floor] -> DOOR_OPEN
  - else above -> MOVE_UP
  - else below -> MOVE_DOWN
  - else stay
  - above wins ties over below.
- MOVE_UP / MOVE_DOWN:
  - travel counter counts 0..TRAVEL_CYCLES-1.
  - At terminal count: floor_status +/-1, counter clears; dir_up set to the travel direction.
  - Arrival decision uses the new floor:
    - req_eff[new] -> DOOR_OPEN
    - else request ahead in dir_up -> same move state
    - else request behind -> reverse move state
    - else IDLE
  - Floor never wraps: moves are only entered with a request strictly ahead, so floor stays within 0..NUM_FLOORS-1.
- DOOR_OPEN:
  - entry clears pending[floor] and loads the door counter with 0.
  - Counts to DOOR_CYCLES-1.
  - call_req[floor] while open resets the door counter to 0 (door reopen/extend); it is not latched.
  - On expiry, priority order:
    - request ahead in dir_up -> that move
    - else request opposite -> opposite move (dir_up flips)
    - else IDLE
- Timing:
  - door asserts the cycle after the entering edge.
  - Minimum door-open duration: DOOR_CYCLES enabled cycles.
  - Minimum one-floor move: TRAVEL_CYCLES enabled cycles.
- Simultaneous events:
  - call for the arrival floor on the arrival edge -> door opens, bit never set in pending.
  - reset has priority over everything.

Optional Feature:
SEG_DISPLAY_EN
- Defined: adds output seg[6:0] (segments a..g, active-high), the registered decode of floor_status.
  - Digits 0..9 shown; floor_status 10 or greater shows dash (only g lit).
  - Reset value: the digit 0 pattern.
  - One cycle behind floor_status.
- Undefined: no seg port and no decode logic.

Decomposition:
- Package elevator_pkg holds:
  - state enum typedef (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN)
  - 7-seg pattern constants SEG_DIGIT[0..9] and SEG_DASH
- One sub-module, elevator_seg7: the registered floor-to-segment decoder, instantiated only under SEG_DISPLAY_EN.

Test Plan:
- NUM_FLOORS=4, TRAVEL=4, DOOR=3; reset, call_req=4'b1000 pulse
  -> MOVE_UP next cycle; floor_status 1,2,3 at 4-cycle intervals
  -> door=1 for 3 cycles, then IDLE; pending=0.
- At floor 0 idle, call_req=4'b0001 -> door=1 next cycle for 3 cycles; moving_up/down stay 0.
- Floor 1 moving up to 3; call floor 0 mid-travel
  -> serves 3 first (door), then MOVE_DOWN to 0.
- Door open at floor 2; call_req=4'b0100 pulsed on 2nd door cycle
  -> door held 3 further cycles; pending[2] stays 0.
- enable=0 for 10 cycles mid-travel -> floor_status and counters frozen; a call arriving meanwhile still sets pending.
- Reset asserted mid-MOVE_UP at floor 2 (async, between edges)
  -> all outputs zero immediately; with SEG_DISPLAY_EN, seg shows 0.
